// File: rtl/coin_feeder_if.sv
// ---------------------------------------------------------------------------
// coin_feeder_if
// Coin link between the customer-side feeder and the newspaper vending FSM.
//   coin[1:0]  : coin code toward the vending machine (00 none, 01 nickel,
//                10 dime; 11 is never driven)
//   newspaper  : vending machine response, high = paper delivered
// Modports:
//   master : the coin feeder (drives coin, observes newspaper)
//   slave  : the vending machine (observes coin, drives newspaper)
// ---------------------------------------------------------------------------
interface coin_feeder_if;
    logic [1:0] coin;
    logic       newspaper;

    modport master (output coin, input newspaper);
    modport slave  (input coin, output newspaper);
endinterface

// File: rtl/coin_feeder.sv
// ---------------------------------------------------------------------------
// coin_feeder
// Customer agent for the vending machine. On start it plays one of four fixed
// payment sequences on the coin link, then waits for the newspaper response
// and reports completion, the credit inserted and a timeout error.
//
// Ports:
//   clock   : system clock, rising edge
//   reset   : synchronous, active-high reset
//   start   : begin a transaction (sampled only in IDLE)
//   mode    : 00=N,N,N  01=N,D  10=D,D  11=D,N
//   vif     : coin link (master side: coin out, newspaper in)
//   busy    : transaction in progress
//   done    : one-cycle completion pulse
//   error   : timeout flag, held from done until the next accepted start
//   credit  : cents inserted in the current or last transaction
//
// state  | meaning
// -------+----------------------------------------------------------
// IDLE   | waiting for start
// DRIVE  | coin code held on the link for PULSE_CYCLES
// GAP    | link held at 00 for GAP_CYCLES between coins
// WAIT   | all coins sent, waiting up to TIMEOUT_CYCLES for newspaper
// FIN    | one-cycle done pulse, then back to IDLE
// ---------------------------------------------------------------------------
module coin_feeder #(
    parameter int PULSE_CYCLES   = 1,
    parameter int GAP_CYCLES     = 2,
    parameter int TIMEOUT_CYCLES = 8
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start,
    input  logic [1:0]           mode,
    coin_feeder_if.master        vif,
    output logic                 busy,
    output logic                 done,
    output logic                 error,
    output logic [4:0]           credit
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DRIVE,
        ST_GAP,
        ST_WAIT,
        ST_FIN
    } state_t;

    localparam logic [1:0] COIN_NONE   = 2'b00;
    localparam logic [1:0] COIN_NICKEL = 2'b01;
    localparam logic [1:0] COIN_DIME   = 2'b10;

    // Down-counter reload values; each phase ends when the counter reads zero.
    localparam logic [7:0] PULSE_LOAD = 8'(PULSE_CYCLES - 1);
    localparam logic [7:0] GAP_LOAD   = 8'(GAP_CYCLES - 1);
    localparam logic [7:0] WAIT_LOAD  = 8'(TIMEOUT_CYCLES - 1);

    state_t     r_state, w_state;
    logic [1:0] r_mode,  w_mode;
    logic [1:0] r_idx,   w_idx;
    logic [7:0] r_tmr,   w_tmr;
    logic [1:0] r_coin,  w_coin;
    logic       r_busy,  w_busy;
    logic       r_done,  w_done;
    logic       r_error, w_error;
    logic [4:0] r_credit, w_credit;

    logic       w_last;
    logic [1:0] w_code_first;
    logic [1:0] w_code_next;

    function automatic logic [1:0] f_code(input logic [1:0] m, input logic [1:0] idx);
        logic [1:0] c;
        case (m)
            2'b00:   c = COIN_NICKEL;
            2'b01:   c = (idx == 2'd0) ? COIN_NICKEL : COIN_DIME;
            2'b10:   c = COIN_DIME;
            default: c = (idx == 2'd0) ? COIN_DIME : COIN_NICKEL;
        endcase
        return c;
    endfunction

    function automatic logic [4:0] f_value(input logic [1:0] c);
        return (c == COIN_DIME) ? 5'd10 : 5'd5;
    endfunction

    // Mode 00 plays three coins, the others two.
    assign w_last       = (r_mode == 2'b00) ? (r_idx == 2'd2) : (r_idx == 2'd1);
    assign w_code_first = f_code(mode, 2'd0);
    assign w_code_next  = f_code(r_mode, r_idx);

    always_comb begin
        w_state  = r_state;
        w_mode   = r_mode;
        w_idx    = r_idx;
        w_tmr    = r_tmr;
        w_coin   = r_coin;
        w_busy   = r_busy;
        w_done   = 1'b0;
        w_error  = r_error;
        w_credit = r_credit;

        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state  = ST_DRIVE;
                    w_mode   = mode;
                    w_idx    = 2'd0;
                    w_tmr    = PULSE_LOAD;
                    w_coin   = w_code_first;
                    w_busy   = 1'b1;
                    w_error  = 1'b0;
                    w_credit = f_value(w_code_first);
                end
            end

            ST_DRIVE: begin
                if (r_tmr == 8'd0) begin
                    w_coin = COIN_NONE;
                    if (w_last) begin
                        w_state = ST_WAIT;
                        w_tmr   = WAIT_LOAD;
                    end else begin
                        w_state = ST_GAP;
                        w_tmr   = GAP_LOAD;
                        w_idx   = r_idx + 2'd1;
                    end
                end else begin
                    w_tmr = r_tmr - 8'd1;
                end
            end

            ST_GAP: begin
                if (r_tmr == 8'd0) begin
                    w_state  = ST_DRIVE;
                    w_tmr    = PULSE_LOAD;
                    w_coin   = w_code_next;
                    w_credit = r_credit + f_value(w_code_next);
                end else begin
                    w_tmr = r_tmr - 8'd1;
                end
            end

            ST_WAIT: begin
                if (r_tmr == 8'd0) begin
                    w_state = ST_FIN;
                    w_busy  = 1'b0;
                    w_done  = 1'b1;
                    w_error = 1'b1;
                end else begin
                    w_tmr = r_tmr - 8'd1;
                end
            end

            ST_FIN: begin
                w_state = ST_IDLE;
                w_busy  = 1'b0;
            end

            default: begin
                w_state = ST_IDLE;
                w_coin  = COIN_NONE;
                w_busy  = 1'b0;
            end
        endcase

        // A delivered paper ends the transaction from any active state,
        // cutting off a pulse in progress and overriding a same-cycle timeout.
        if ((r_state == ST_DRIVE || r_state == ST_GAP || r_state == ST_WAIT) && vif.newspaper) begin
            w_state = ST_FIN;
            w_coin  = COIN_NONE;
            w_busy  = 1'b0;
            w_done  = 1'b1;
            w_error = 1'b0;
            w_tmr   = r_tmr;
            w_idx   = r_idx;
            w_credit = r_credit;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_mode   <= 2'b00;
            r_idx    <= 2'd0;
            r_tmr    <= 8'd0;
            r_coin   <= COIN_NONE;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_error  <= 1'b0;
            r_credit <= 5'd0;
        end else begin
            r_state  <= w_state;
            r_mode   <= w_mode;
            r_idx    <= w_idx;
            r_tmr    <= w_tmr;
            r_coin   <= w_coin;
            r_busy   <= w_busy;
            r_done   <= w_done;
            r_error  <= w_error;
            r_credit <= w_credit;
        end
    end

    assign vif.coin = r_coin;
    assign busy     = r_busy;
    assign done     = r_done;
    assign error    = r_error;
    assign credit   = r_credit;

endmodule

// File: tb/tb_coin_feeder.sv
// ---------------------------------------------------------------------------
// tb_coin_feeder
// Directed bench for coin_feeder. dut1 uses default timing, dut2 uses
// PULSE_CYCLES=3 / GAP_CYCLES=1. Offsets below count periods after the edge
// that sampled start (offset 1 = first cycle showing busy).
// ---------------------------------------------------------------------------
module tb_coin_feeder;

    logic       clock = 1'b0;
    logic       reset;
    logic       start1, start2;
    logic [1:0] mode;

    logic       busy1, done1, error1;
    logic [4:0] credit1;
    logic       busy2, done2, error2;
    logic [4:0] credit2;

    coin_feeder_if if1();
    coin_feeder_if if2();

    coin_feeder dut1 (
        .clock  (clock),
        .reset  (reset),
        .start  (start1),
        .mode   (mode),
        .vif    (if1.master),
        .busy   (busy1),
        .done   (done1),
        .error  (error1),
        .credit (credit1)
    );

    coin_feeder #(
        .PULSE_CYCLES   (3),
        .GAP_CYCLES     (1),
        .TIMEOUT_CYCLES (8)
    ) dut2 (
        .clock  (clock),
        .reset  (reset),
        .start  (start2),
        .mode   (mode),
        .vif    (if2.master),
        .busy   (busy2),
        .done   (done2),
        .error  (error2),
        .credit (credit2)
    );

    always #5 clock = ~clock;

    // Observation mux so one trace routine serves both instances.
    logic       sel;
    logic [1:0] s_coin;
    logic       s_busy, s_done, s_err;
    logic [4:0] s_credit;
    assign s_coin   = sel ? if2.coin : if1.coin;
    assign s_busy   = sel ? busy2    : busy1;
    assign s_done   = sel ? done2    : done1;
    assign s_err    = sel ? error2   : error1;
    assign s_credit = sel ? credit2  : credit1;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    logic [1:0] tr_coin   [0:47];
    logic       tr_done   [0:47];
    logic       tr_err    [0:47];
    logic       tr_busy   [0:47];
    logic [4:0] tr_credit [0:47];
    int         done_at;
    int         n_coin11;

    // Start a transaction and trace it until done (bounded). The vend model
    // raises newspaper one cycle after credit reaches p_credit (0 = never),
    // or for the single cycle at offset p_off (0 = never).
    task automatic run(input logic which, input logic [1:0] m,
                       input logic [4:0] p_credit, input int p_off);
        logic hit;
        logic news;
        hit = 1'b0;
        sel = which;
        mode = m;
        if (which) start2 = 1'b1; else start1 = 1'b1;
        step();
        start1 = 1'b0;
        start2 = 1'b0;
        done_at  = 0;
        n_coin11 = 0;
        for (int c = 1; c < 48; c++) begin
            tr_coin[c]   = s_coin;
            tr_done[c]   = s_done;
            tr_err[c]    = s_err;
            tr_busy[c]   = s_busy;
            tr_credit[c] = s_credit;
            if (s_coin == 2'b11) n_coin11++;
            if (s_done) begin
                done_at = c;
                break;
            end
            news = hit || (c == p_off);
            if (which) if2.newspaper = news; else if1.newspaper = news;
            hit = (p_credit != 5'd0) && (s_credit == p_credit);
            step();
        end
        if1.newspaper = 1'b0;
        if2.newspaper = 1'b0;
        step();
        check("done_one_cycle", s_done, 0);
        check("coin_never_11", n_coin11, 0);
    endtask

    initial begin
        reset  = 1'b1;
        start1 = 1'b0;
        start2 = 1'b0;
        mode   = 2'b00;
        sel    = 1'b0;
        if1.newspaper = 1'b0;
        if2.newspaper = 1'b0;
        step();
        step();
        check("rst_coin",   if1.coin, 0);
        check("rst_busy",   busy1,    0);
        check("rst_done",   done1,    0);
        check("rst_error",  error1,   0);
        check("rst_credit", credit1,  0);
        check("rst2_coin",  if2.coin, 0);
        check("rst2_busy",  busy2,    0);
        reset = 1'b0;
        step();
        step();

        // mode 00, paper one cycle after credit reaches 15
        run(1'b0, 2'b00, 5'd15, 0);
        check("t1_coin1",  tr_coin[1], 1);
        check("t1_busy1",  tr_busy[1], 1);
        check("t1_cred1",  tr_credit[1], 5);
        check("t1_gap2",   tr_coin[2], 0);
        check("t1_gap3",   tr_coin[3], 0);
        check("t1_coin4",  tr_coin[4], 1);
        check("t1_cred4",  tr_credit[4], 10);
        check("t1_coin7",  tr_coin[7], 1);
        check("t1_cred7",  tr_credit[7], 15);
        check("t1_wait8",  tr_coin[8], 0);
        check("t1_done_at", done_at, 9);
        check("t1_err",    tr_err[9], 0);
        check("t1_busy9",  tr_busy[9], 0);
        check("t1_cred9",  tr_credit[9], 15);
        step();
        check("t1_cred_hold", credit1, 15);

        // mode 01, paper at 15
        run(1'b0, 2'b01, 5'd15, 0);
        check("t2_coin1",  tr_coin[1], 1);
        check("t2_gap2",   tr_coin[2], 0);
        check("t2_gap3",   tr_coin[3], 0);
        check("t2_coin4",  tr_coin[4], 2);
        check("t2_cred4",  tr_credit[4], 15);
        check("t2_done_at", done_at, 6);
        check("t2_err",    tr_err[6], 0);
        check("t2_cred",   tr_credit[6], 15);

        // mode 10, paper delivered at 20 with no change
        run(1'b0, 2'b10, 5'd20, 0);
        check("t3_coin1",  tr_coin[1], 2);
        check("t3_cred1",  tr_credit[1], 10);
        check("t3_coin4",  tr_coin[4], 2);
        check("t3_cred4",  tr_credit[4], 20);
        check("t3_done_at", done_at, 6);
        check("t3_err",    tr_err[6], 0);

        // mode 11, no paper: timeout after 8 WAIT cycles
        run(1'b0, 2'b11, 5'd0, 0);
        check("t4_coin1",  tr_coin[1], 2);
        check("t4_coin4",  tr_coin[4], 1);
        check("t4_cred4",  tr_credit[4], 15);
        check("t4_busy12", tr_busy[12], 1);
        check("t4_done12", tr_done[12], 0);
        check("t4_done_at", done_at, 13);
        check("t4_err",    tr_err[13], 1);
        check("t4_cred",   tr_credit[13], 15);
        step();
        step();
        check("t4_err_hold", error1, 1);

        // mode 00, paper during the first gap: abort
        run(1'b0, 2'b00, 5'd0, 2);
        check("t5_err_clr", tr_err[1], 0);
        check("t5_coin1",  tr_coin[1], 1);
        check("t5_done_at", done_at, 3);
        check("t5_coin3",  tr_coin[3], 0);
        check("t5_cred",   tr_credit[3], 5);
        check("t5_err",    tr_err[3], 0);

        // start/mode while busy ignored, then reset mid-DRIVE (dut1)
        sel = 1'b0;
        mode = 2'b00;
        start1 = 1'b1;
        step();
        start1 = 1'b0;
        step();
        start1 = 1'b1;
        mode = 2'b10;
        step();
        start1 = 1'b0;
        mode = 2'b00;
        step();
        check("t6_coin4",  if1.coin, 1);
        check("t6_cred4",  credit1, 10);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("t6_rst_coin", if1.coin, 0);
        check("t6_rst_busy", busy1, 0);
        check("t6_rst_cred", credit1, 0);

        // reset in the middle of a 3-cycle pulse (dut2)
        sel = 1'b1;
        mode = 2'b01;
        start2 = 1'b1;
        step();
        start2 = 1'b0;
        step();
        check("t7_coin2",  if2.coin, 1);
        check("t7_busy2",  busy2, 1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("t7_rst_coin", if2.coin, 0);
        check("t7_rst_busy", busy2, 0);
        check("t7_rst_cred", credit2, 0);
        step();

        // dut2 mode 01, no paper: 3-cycle pulses, 1-cycle gap, timeout
        run(1'b1, 2'b01, 5'd0, 0);
        check("t8_coin1",  tr_coin[1], 1);
        check("t8_coin2",  tr_coin[2], 1);
        check("t8_coin3",  tr_coin[3], 1);
        check("t8_gap4",   tr_coin[4], 0);
        check("t8_coin5",  tr_coin[5], 2);
        check("t8_coin7",  tr_coin[7], 2);
        check("t8_cred5",  tr_credit[5], 15);
        check("t8_wait8",  tr_coin[8], 0);
        check("t8_busy15", tr_busy[15], 1);
        check("t8_done_at", done_at, 16);
        check("t8_err",    tr_err[16], 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/coin_feeder.md
Name: coin_feeder

Overview:
Initiator side of the vend coin interface: drives coin[1:0] pulses into the newspaper vending FSM and waits for its newspaper response. On start, it plays one of four fixed payment sequences (three nickels; nickel then dime; dime then dime; dime then nickel). It reports completion, the credit inserted, and a timeout error. It serves as the bench/system-side customer agent for the vending machine.

Parameters:
PULSE_CYCLES, 1, clock cycles each coin code is held non-zero (1..15)
GAP_CYCLES, 2, clock cycles coin held at 0 between consecutive coins (1..15)
TIMEOUT_CYCLES, 8, cycles to wait for newspaper after the last coin before flagging error (1..255)

Ports:
clock  input  1  system clock; all logic on rising edge
reset  input  1  synchronous, active-high reset
start  input  1  begin a transaction; sampled only in IDLE
mode  input  2  sequence select: 00=N,N,N; 01=N,D; 10=D,D; 11=D,N
newspaper  input  1  vend machine output; high = paper delivered
coin  output  2  coin code to vend machine: 00 none, 01 nickel, 10 dime; 11 never driven
busy  output  1  transaction in progress
done  output  1  one-cycle completion pulse
error  output  1  timeout flag, valid from the done pulse until the next accepted start or reset
credit  output  5  cents inserted in the current or last transaction (0..20)

Behaviour:
- Reset (synchronous, active-high; applies at any state, including mid-pulse): coin=00, busy=0, done=0, error=0, credit=0, state=IDLE. All counters and the latched mode are cleared.
- All outputs are registered.
- States: IDLE, DRIVE, GAP, WAIT, FIN.
- IDLE: if start=1 at an edge, latch mode, clear error, set credit=0, and go to DRIVE with the first coin. busy=1 and coin=code1 are visible in the next cycle.
- DRIVE: coin=current code for exactly PULSE_CYCLES cycles. credit adds 5 or 10 on entry to DRIVE, so the new credit is visible together with the coin.
  - After the pulse, if more coins remain in the sequence: go to GAP.
  - Otherwise: go to WAIT.
- GAP: coin=00 for exactly GAP_CYCLES cycles, then go to DRIVE with the next coin.
- WAIT: coin=00. A counter increments each cycle.
  - If the counter reaches TIMEOUT_CYCLES without newspaper: set error=1 and go to FIN.
- Newspaper sampled high at any edge in DRIVE, GAP or WAIT:
  - Abort any remaining coins and go to FIN.
  - error=0.
  - coin=00 from the next cycle, even if a pulse was in progress.
- FIN (one cycle): done=1, busy=0, coin=00. Unconditionally return to IDLE.
- Hold rules:
  - credit holds its value until the next accepted start.
  - start and mode are ignored while busy or in FIN.
  - start asserted in the same cycle that FIN returns to IDLE is accepted only if it is still high at the following IDLE edge.
- newspaper is ignored in IDLE and FIN.
- Simultaneous reset and start: reset wins.
- Sequence lengths: mode 00 is 3 coins; modes 01, 10 and 11 are 2 coins. Maximum credit is 20 (mode 10); no overflow is possible.
- Latency with defaults, for start sampled at edge k:
  - Coin pulses occupy cycles k+1, k+4, k+7 (three-coin sequence).
  - WAIT begins at k+8.
  - Timeout done occurs at k+16 at the earliest, with no newspaper.

Test Plan:
- Reset then mode=00 start at edge 5, bench vend model raises newspaper one cycle after credit reaches 15 -> coin=01 in cycles 6, 9, 12; credit 5/10/15; done=1 once around cycle 14; error=0; credit stays 15.
- mode=01 -> coin sequence 01 then 10 with exactly 2 zero cycles between; done pulse; credit=15; error=0.
- mode=10, vend model never returns change -> both dimes driven; credit=20; done; error=0; coin never 11.
- mode=11, newspaper held low -> coins 10, 01; after 8 WAIT cycles: done=1, error=1, credit=15; error clears on next start.
- newspaper forced high during the GAP after the first coin (mode 00) -> no further coins; done next cycle; credit=5; error=0.
- Reset asserted mid-DRIVE, plus start pulsed while busy -> coin=00 and busy=0 on the next cycle; extra start ignored; PULSE_CYCLES=3, GAP_CYCLES=1 rerun gives 3-cycle pulses with 1-cycle gaps.
